// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) for a shared-datapath RV32 core, with
// memory handshake timeout, ECALL halt detection and cycle/retire counters.
module multicycle_control_fsm #(
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] HALT_A7_VAL = 32'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [31:0]      rf_x17,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             is_halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  logic [2:0]        state_q, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timeout;

  // Handshake: mem_req and its qualifiers (mem_we, i_or_d) stay constant for as long as the
  // FSM sits in IF or MEM; mem_ready only matters while mem_req=1, and ready in the first
  // request cycle completes the access with no extra wait.
  always_comb begin
    state_next = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op_sel = 2'd0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            state_next = S_ID;
          end
        end
        S_ID: begin
          alu_src_b = 2'd1;
          case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR: state_next = S_EX;
            OP_SYS: begin
              if (rf_x17 == HALT_A7_VAL) begin
                state_next = S_HALT;
              end else begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                state_next = S_IF;
              end
            end
            default: state_next = S_FAULT;
          endcase
        end
        S_EX: begin
          case (opcode)
            OP_R, OP_I: begin
              alu_src_a  = 1'b1;
              alu_src_b  = (opcode == OP_I) ? 2'd1 : 2'd0;
              alu_op_sel = 2'd1;
              state_next = S_WB;
            end
            OP_LD, OP_ST: begin
              alu_src_a  = 1'b1;
              alu_src_b  = 2'd1;
              state_next = S_MEM;
            end
            OP_BR: begin
              alu_src_a  = 1'b1;
              alu_op_sel = 2'd2;
              pc_write   = 1'b1;
              pc_source  = bcond ? 2'd1 : 2'd2;
              state_next = S_IF;
            end
            OP_JAL: begin
              reg_write  = 1'b1;
              wb_sel     = 2'd2;
              pc_write   = 1'b1;
              pc_source  = 2'd1;
              state_next = S_IF;
            end
            OP_JALR: begin
              alu_src_a  = 1'b1;
              alu_src_b  = 2'd1;
              reg_write  = 1'b1;
              wb_sel     = 2'd2;
              pc_write   = 1'b1;
              state_next = S_IF;
            end
            default: state_next = S_FAULT;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = (opcode == OP_ST);
          if (mem_ready) begin
            if (opcode == OP_LD) begin
              state_next = S_WB;
            end else begin
              pc_write   = 1'b1;
              pc_source  = 2'd2;
              state_next = S_IF;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          wb_sel     = (opcode == OP_LD) ? 2'd1 : 2'd0;
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          state_next = S_IF;
        end
        default: state_next = state_q;
      endcase
    end
    mem_wait = mem_req & ~mem_ready;
    timeout  = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    if (timeout) state_next = S_FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IF;
      wait_cnt    <= '0;
      is_halted   <= 1'b0;
      mem_fault   <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q   <= state_next;
      // Consecutive stall cycles only; any completion or state change restarts the count.
      wait_cnt  <= (mem_wait && state_next == state_q) ? wait_cnt + 1'b1 : '0;
      is_halted <= is_halted | (state_next == S_HALT);
      mem_fault <= mem_fault | (state_next == S_FAULT);
      if (state_q <= S_WB) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_write) instret_cnt <= instret_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction state walks, wait states,
// halt, timeout fault, illegal opcode and asynchronous reset abort.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [31:0] rf_x17;
  logic        bcond;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a, reg_write;
  logic [1:0]  pc_source, alu_src_b, alu_op_sel, wb_sel;
  logic [2:0]  state;
  logic        is_halted, mem_fault;
  logic [31:0] cycle_cnt, instret_cnt;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(4), .HALT_A7_VAL(32'd10)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rf_x17(rf_x17), .bcond(bcond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .is_halted(is_halted),
    .mem_fault(mem_fault), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the full control bundle as one packed word.
  task automatic ctrl(input string tag, input logic mreq, input logic mwe, input logic iod,
                      input logic irw, input logic pcw, input logic [1:0] pcs,
                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                      input logic rw, input logic [1:0] wbs);
    chk(tag, {17'd0, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
              alu_src_b, alu_op_sel, reg_write, wb_sel},
             {17'd0, mreq, mwe, iod, irw, pcw, pcs, asa, asb, aop, rw, wbs});
  endtask

  task automatic counters(input string tag, input int cyc, input int ret);
    chk({tag, "_cycle"}, cycle_cnt, cyc);
    chk({tag, "_instret"}, instret_cnt, ret);
  endtask

  initial begin
    reset = 1'b0; opcode = 7'd0; rf_x17 = 32'd0; bcond = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", state, 0);
    ctrl("rst_ctrl", 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    counters("rst", 0, 0);
    chk("rst_halted", is_halted, 0);
    chk("rst_fault", mem_fault, 0);

    // ADD then ADDI, zero wait
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("add_if_state", state, 0);
    ctrl("add_if", 1, 0, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    tick();
    opcode = OP_R; #1;
    chk("add_id_state", state, 1);
    ctrl("add_id", 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0, 2'd0);
    tick();
    chk("add_ex_state", state, 2);
    ctrl("add_ex", 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0, 2'd0);
    tick();
    chk("add_wb_state", state, 4);
    ctrl("add_wb", 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 1, 2'd0);
    tick();
    counters("add", 4, 1);
    chk("addi_if_state", state, 0);
    tick();
    opcode = OP_I; #1;
    chk("addi_id_state", state, 1);
    tick();
    chk("addi_ex_state", state, 2);
    ctrl("addi_ex", 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd1, 0, 2'd0);
    tick();
    chk("addi_wb_state", state, 4);
    tick();
    chk("addi_done_state", state, 0);
    counters("addi", 8, 2);

    // LW with three not-ready cycles in MEM
    tick();
    opcode = OP_LD; #1;
    tick();
    ctrl("lw_ex", 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 2'd0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", state, 3);
      ctrl("lw_wait", 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_ready_state", state, 3);
    ctrl("lw_ready", 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    tick();
    chk("lw_wb_state", state, 4);
    ctrl("lw_wb", 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 1, 2'd1);
    tick();
    counters("lw", 16, 3);

    // BEQ taken, then not taken
    tick();
    opcode = OP_BR; #1;
    tick();
    bcond = 1'b1; #1;
    ctrl("beq_taken", 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd2, 0, 2'd0);
    tick();
    chk("beq_taken_state", state, 0);
    counters("beq_taken", 19, 4);
    tick(); tick();
    bcond = 1'b0; #1;
    ctrl("beq_not", 0, 0, 0, 0, 1, 2'd2, 1, 2'd0, 2'd2, 0, 2'd0);
    tick();
    counters("beq_not", 22, 5);

    // SW, JAL, JALR
    tick();
    opcode = OP_ST; #1;
    tick(); tick();
    ctrl("sw_mem", 1, 1, 1, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 2'd0);
    tick();
    counters("sw", 26, 6);
    tick();
    opcode = OP_JAL; #1;
    tick();
    ctrl("jal_ex", 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 1, 2'd2);
    tick();
    counters("jal", 29, 7);
    tick();
    opcode = OP_JALR; #1;
    tick();
    ctrl("jalr_ex", 0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 2'd0, 1, 2'd2);
    tick();
    counters("jalr", 32, 8);

    // ECALL without and with halt
    tick();
    opcode = OP_SYS; rf_x17 = 32'd5; #1;
    ctrl("ecall_go", 0, 0, 0, 0, 1, 2'd2, 0, 2'd1, 2'd0, 0, 2'd0);
    tick();
    chk("ecall_go_state", state, 0);
    counters("ecall_go", 34, 9);
    tick();
    rf_x17 = 32'd10; #1;
    ctrl("ecall_halt_id", 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0, 2'd0);
    tick();
    chk("halt_state", state, 5);
    chk("halt_flag", is_halted, 1);
    ctrl("halt_ctrl", 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    tick(); tick();
    chk("halt_stay", state, 5);
    counters("halt_frozen", 36, 9);

    // Fetch timeout with MEM_TIMEOUT=4
    reset = 1'b0; #1;
    chk("rst2_halted", is_halted, 0);
    counters("rst2", 0, 0);
    reset = 1'b1; opcode = 7'd0; mem_ready = 1'b0; #1;
    tick(); tick(); tick(); tick();
    chk("to_wait_state", state, 0);
    tick();
    chk("to_fault_state", state, 6);
    chk("to_fault_flag", mem_fault, 1);
    ctrl("to_fault_ctrl", 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    tick();
    counters("to_frozen", 5, 0);

    // Illegal opcode faults from ID
    reset = 1'b0; #1;
    chk("rst3_fault", mem_fault, 0);
    reset = 1'b1; mem_ready = 1'b1; #1;
    tick();
    opcode = OP_LUI; #1;
    tick();
    chk("illegal_state", state, 6);
    chk("illegal_fault", mem_fault, 1);
    counters("illegal", 2, 0);

    // Reset during a MEM wait
    reset = 1'b0; #1;
    reset = 1'b1; #1;
    tick();
    opcode = OP_LD; #1;
    tick(); tick();
    mem_ready = 1'b0; #1;
    tick();
    chk("abort_pre_state", state, 3);
    chk("abort_pre_req", mem_req, 1);
    reset = 1'b0; #1;
    chk("abort_state", state, 0);
    ctrl("abort_ctrl", 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    counters("abort", 0, 0);
    reset = 1'b1; #1;
    chk("abort_rel_state", state, 0);
    ctrl("abort_rel_ctrl", 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
    counters("abort_rel", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
